// File: rtl/remote_command_tx.sv
// rtl/remote_command_tx.sv - hub-to-device serial command frame transmitter (optional parity via REMOTE_TX_PARITY_EN)
module remote_command_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] device_id,
    input  logic [3:0] command,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       tx,
    output logic       busy,
    output logic [7:0] frames_sent
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef REMOTE_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic [7:0]  frames_q, frames_d;
`ifdef REMOTE_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic accept;
    logic bit_done;

    assign cmd_ready   = (state_q == IDLE) && !rst;
    assign accept      = cmd_valid && cmd_ready;
    assign bit_done    = (timer_q == BIT_LAST);
    assign busy        = (state_q != IDLE);
    assign tx          = tx_q;
    assign frames_sent = frames_q;

    // Next-state, bit timing and next tx level; tx is computed one cycle ahead so the line is registered
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        frames_d  = frames_q;
`ifdef REMOTE_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        timer_d   = (state_q == IDLE || bit_done) ? 16'd0 : timer_q + 16'd1;

        case (state_q)
            IDLE: begin
                bit_idx_d = 3'd0;
                tx_d      = 1'b1;
                if (accept) begin
                    state_d = START;
                    shift_d = {device_id, command};
`ifdef REMOTE_TX_PARITY_EN
                    parity_d = ^{device_id, command};
`endif
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
`ifdef REMOTE_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef REMOTE_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    state_d  = IDLE;
                    tx_d     = 1'b1;
                    frames_d = frames_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset abandons any partial frame without counting it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            frames_q  <= 8'd0;
`ifdef REMOTE_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            frames_q  <= frames_d;
`ifdef REMOTE_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_remote_command_tx.sv
// tb/tb_remote_command_tx.sv - directed self-checking bench for remote_command_tx
module tb_remote_command_tx;

    localparam int CPB = 4;
`ifdef REMOTE_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] device_id = 4'd0;
    logic [3:0] command = 4'd0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       tx;
    logic       busy;
    logic [7:0] frames_sent;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_frames = 8'd0;

    remote_command_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .device_id   (device_id),
        .command     (command),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .tx          (tx),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    // Present a command at a falling edge and return just after the accepting rising edge
    task automatic start_frame(input logic [7:0] b, input string nm);
        @(negedge clk);
        {device_id, command} = b;
        cmd_valid = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept: got %b expected 1", nm, cmd_ready);
        end
        @(posedge clk);
    endtask

    // Check every cycle of a frame of byte b, then the first cycle after it
    task automatic check_frame(input logic [7:0] b, input string nm, input bit hold,
                               input logic [7:0] nb, input int pulse_at);
        logic exp_bits [11];
        exp_bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) exp_bits[k+1] = b[k];
`ifdef REMOTE_TX_PARITY_EN
        exp_bits[9] = ^b;
`endif
        exp_bits[NB-1] = 1'b1;
        for (int i = 0; i < NB * CPB; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (hold) {device_id, command} = nb;
                else cmd_valid = 1'b0;
            end
            if (pulse_at >= 0 && i == pulse_at) begin
                {device_id, command} = nb;
                cmd_valid = 1'b1;
            end
            if (pulse_at >= 0 && i == pulse_at + 1) cmd_valid = 1'b0;
            checks++;
            if (tx !== exp_bits[i / CPB]) begin
                errors++;
                $display("FAIL %s tx_bit%0d_cyc%0d: got %b expected %b", nm, i / CPB, i % CPB, tx, exp_bits[i / CPB]);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy_cyc%0d: got %b expected 1", nm, i, busy);
            end
        end
        @(negedge clk);
        exp_frames = exp_frames + 8'd1;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || tx !== 1'b1) begin
            errors++;
            $display("FAIL %s end_state: busy=%b ready=%b tx=%b expected 0 1 1", nm, busy, cmd_ready, tx);
        end
        checks++;
        if (frames_sent !== exp_frames) begin
            errors++;
            $display("FAIL %s frames_sent: got %0d expected %0d", nm, frames_sent, exp_frames);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || frames_sent !== 8'd0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: tx=%b busy=%b frames=%0d ready=%b expected 1 0 0 0", tx, busy, frames_sent, cmd_ready);
        end
        rst = 1'b0;
        exp_frames = 8'd0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_single;
        start_frame(8'hA5, "single");
        check_frame(8'hA5, "single", 1'b0, 8'h00, -1);
    endtask

    task automatic test_parity;
        start_frame(8'h01, "parity");
        check_frame(8'h01, "parity", 1'b0, 8'h00, -1);
    endtask

    task automatic test_back_to_back;
        start_frame(8'h12, "b2b_first");
        check_frame(8'h12, "b2b_first", 1'b1, 8'h34, -1);
        @(posedge clk);
        check_frame(8'h34, "b2b_second", 1'b0, 8'h00, -1);
    endtask

    task automatic test_ignore_busy;
        start_frame(8'h3C, "ignore");
        check_frame(8'h3C, "ignore", 1'b0, 8'hC3, 10);
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || tx !== 1'b1) begin
                errors++;
                $display("FAIL ignore_no_extra: busy=%b tx=%b expected 0 1", busy, tx);
            end
        end
    endtask

    task automatic test_reset_mid_and_wrap;
        int   inc;
        logic [7:0] prev;
        start_frame(8'h77, "midreset");
        for (int i = 0; i <= 17; i++) begin
            @(negedge clk);
            if (i == 0) cmd_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || frames_sent !== 8'd0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: tx=%b frames=%0d busy=%b ready=%b expected 1 0 0 0", tx, frames_sent, busy, cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_frames = 8'd0;
        start_frame(8'h5A, "after_reset");
        check_frame(8'h5A, "after_reset", 1'b0, 8'h00, -1);

        inc = 0;
        prev = frames_sent;
        cmd_valid = 1'b1;
        for (int c = 0; c < 260 * (NB * CPB + 1); c++) begin
            @(negedge clk);
            if (frames_sent !== prev) begin
                inc++;
                prev = frames_sent;
                if (inc == 255) begin
                    cmd_valid = 1'b0;
                    break;
                end
            end
        end
        checks++;
        if (inc != 255) begin
            errors++;
            $display("FAIL wrap_timeout: got %0d frames expected 255", inc);
        end
        checks++;
        if (frames_sent !== 8'd0) begin
            errors++;
            $display("FAIL wrap_value: got %0d expected 0", frames_sent);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_idle: busy=%b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_and_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
